// File: rtl/deserializer_if.sv
// ---------------------------------------------------------------------------
// deserializer_if
//   Bundles the serial input and parallel output signals of the deserializer.
//   Signal names match the deserializer port names.
//
//   Signals:
//     ser_data_i        serial data bit, MSB of the word first
//     ser_data_val_i    qualifies ser_data_i, one bit per high cycle
//     deser_data_o      assembled, left-aligned word
//     deser_data_mod_o  number of valid bits in deser_data_o (0 = all valid)
//     deser_data_val_o  one-cycle pulse qualifying deser_data_o/_mod_o
//     busy_o            high while a burst is partially collected
//
//   Modports:
//     master  serial source side (drives serial input, observes outputs)
//     slave   deserializer side
// ---------------------------------------------------------------------------
interface deserializer_if #(
  parameter int unsigned DATA_BUS_WIDTH = 16,
  parameter int unsigned DATA_MOD_WIDTH = 4
);

  logic                      ser_data_i;
  logic                      ser_data_val_i;
  logic [DATA_BUS_WIDTH-1:0] deser_data_o;
  logic [DATA_MOD_WIDTH-1:0] deser_data_mod_o;
  logic                      deser_data_val_o;
  logic                      busy_o;

  modport master (
    output ser_data_i,
    output ser_data_val_i,
    input  deser_data_o,
    input  deser_data_mod_o,
    input  deser_data_val_o,
    input  busy_o
  );

  modport slave (
    input  ser_data_i,
    input  ser_data_val_i,
    output deser_data_o,
    output deser_data_mod_o,
    output deser_data_val_o,
    output busy_o
  );

endinterface

// File: rtl/deserializer.sv
// ---------------------------------------------------------------------------
// deserializer
//   Collects an MSB-first serial bit stream into left-aligned parallel words.
//   A burst is a run of consecutive cycles with ser_data_val_i high, capped at
//   DATA_BUS_WIDTH bits. A full burst is emitted with mod 0; a burst that ends
//   early with at least 3 bits is emitted with mod = bit count; shorter bursts
//   are dropped. Output pulses one cycle after the last accepted bit (full
//   word) or after the terminating low-valid cycle (partial word).
//
//   Ports:
//     clk_i   single clock, rising edge
//     srst_i  synchronous active-high reset
//     bus     deserializer_if.slave (serial input, parallel output, busy)
// ---------------------------------------------------------------------------
module deserializer #(
  parameter int unsigned DATA_BUS_WIDTH = 16,
  parameter int unsigned DATA_MOD_WIDTH = 4
) (
  input  logic           clk_i,
  input  logic           srst_i,
  deserializer_if.slave  bus
);

  if (DATA_BUS_WIDTH != 2**DATA_MOD_WIDTH) begin : g_param_check
    $error("deserializer: DATA_BUS_WIDTH must equal 2**DATA_MOD_WIDTH");
  end

  typedef enum logic {
    IDLE_S,
    RECV_S
  } state_t;

  localparam logic [DATA_MOD_WIDTH:0] CNT_LAST = (DATA_MOD_WIDTH+1)'(DATA_BUS_WIDTH - 1);
  localparam logic [DATA_MOD_WIDTH:0] CNT_MIN  = (DATA_MOD_WIDTH+1)'(3);

  state_t                    state;
  logic [DATA_MOD_WIDTH:0]   bit_cnt;
  logic [DATA_BUS_WIDTH-1:0] shift_reg;
  logic [DATA_BUS_WIDTH-1:0] word_next;
  logic [DATA_MOD_WIDTH-1:0] bit_idx;

  logic [DATA_BUS_WIDTH-1:0] data_q;
  logic [DATA_MOD_WIDTH-1:0] mod_q;
  logic                      val_q;

  // Bit k (1-based) lands at index W-k; with W a power of two, W-1-cnt is
  // simply the bitwise inverse of the low count bits.
  assign bit_idx = ~bit_cnt[DATA_MOD_WIDTH-1:0];

  // The word as it would look with the current serial bit inserted. A new
  // burst starts from zero so unused low bits of a partial word read as 0.
  always_comb begin
    // NOTE: full default first so every path assigns word_next -- no latch.
    word_next          = (state == RECV_S) ? shift_reg : '0;
    word_next[bit_idx] = bus.ser_data_i;
  end

  // NOTE: the assembly register carries no reset; every burst rebuilds it
  // from zero on its first bit, so its contents before that never matter.
  always_ff @(posedge clk_i) begin
    if (bus.ser_data_val_i) begin
      shift_reg <= word_next;
    end
  end

  // NOTE: non-blocking assignments throughout, so every register samples the
  // pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state   <= IDLE_S;
      bit_cnt <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
    end else begin
      val_q <= 1'b0;
      case (state)
        IDLE_S: begin
          if (bus.ser_data_val_i) begin
            bit_cnt <= (DATA_MOD_WIDTH+1)'(1);
            state   <= RECV_S;
          end
        end
        RECV_S: begin
          if (bus.ser_data_val_i) begin
            if (bit_cnt == CNT_LAST) begin
              // Full word: emit now and drop back to IDLE_S so a still-high
              // valid next cycle starts the next word without a gap.
              data_q  <= word_next;
              mod_q   <= '0;
              val_q   <= 1'b1;
              bit_cnt <= '0;
              state   <= IDLE_S;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            // Burst ended early; runs shorter than 3 bits are discarded.
            if (bit_cnt >= CNT_MIN) begin
              data_q <= shift_reg;
              mod_q  <= bit_cnt[DATA_MOD_WIDTH-1:0];
              val_q  <= 1'b1;
            end
            bit_cnt <= '0;
            state   <= IDLE_S;
          end
        end
        default: begin
          bit_cnt <= '0;
          state   <= IDLE_S;
        end
      endcase
    end
  end

  assign bus.deser_data_o     = data_q;
  assign bus.deser_data_mod_o = mod_q;
  assign bus.deser_data_val_o = val_q;
  assign bus.busy_o           = (bit_cnt != '0);

endmodule

// File: tb/tb_deserializer.sv
// ---------------------------------------------------------------------------
// tb_deserializer
//   Directed and random-loopback stimulus for the 16-bit deserializer.
//   Expected words are queued when their terminating stimulus is driven,
//   tagged with the cycle in which the output pulse must appear, and are
//   popped and compared by a monitor on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_deserializer;

  localparam int unsigned W = 16;
  localparam int unsigned M = 4;

  typedef struct {
    logic [W-1:0] data;
    logic [M-1:0] mod;
    int           due;
  } exp_t;

  logic clk_i;
  logic srst_i;
  int   cyc;
  int   tests_run;
  int   tests_failed;
  exp_t sb_q[$];
  exp_t mon_e;

  deserializer_if #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(M)) bus ();

  deserializer #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(M)) dut (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .bus    (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of serial input; returns 1 ns after the sampling edge.
  task automatic cyc_drive(input logic v, input logic d);
    bus.ser_data_val_i = v;
    bus.ser_data_i     = d;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_drive(1'b0, 1'($urandom));
  endtask

  // Reference: top n bits of w survive, mod is n modulo the word width.
  task automatic expect_word(input logic [W-1:0] w, input int n);
    exp_t         e;
    logic [W-1:0] ones;
    ones   = '1;
    e.data = w & ~(ones >> n);
    e.mod  = M'(n % W);
    e.due  = cyc + 1;
    sb_q.push_back(e);
  endtask

  // Serial source: n bits of w MSB first, optionally followed by one low cycle.
  task automatic send_burst(input logic [W-1:0] w, input int n, input bit term);
    for (int i = 0; i < n; i++) begin
      if (i == n - 1 && n == W) expect_word(w, W);
      cyc_drive(1'b1, w[W-1-i]);
    end
    if (term) begin
      if (n >= 3 && n < W) expect_word(w, n);
      cyc_drive(1'b0, 1'($urandom));
    end
  endtask

  // Output monitor / scoreboard consumer.
  always @(negedge clk_i) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      mon_e = sb_q.pop_front();
      check("pulse_val",  32'(bus.deser_data_val_o), 32'(1'b1));
      check("pulse_data", 32'(bus.deser_data_o),     32'(mon_e.data));
      check("pulse_mod",  32'(bus.deser_data_mod_o), 32'(mon_e.mod));
    end else if (bus.deser_data_val_o !== 1'b0) begin
      check("spurious_pulse", 32'(bus.deser_data_val_o), 32'(1'b0));
    end
  end

  initial begin
    logic [W-1:0] rw;
    int           rm;

    tests_run           = 0;
    tests_failed        = 0;
    srst_i              = 1'b1;
    bus.ser_data_i      = 1'b0;
    bus.ser_data_val_i  = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_data", 32'(bus.deser_data_o),     32'(0));
    check("rst_mod",  32'(bus.deser_data_mod_o), 32'(0));
    check("rst_val",  32'(bus.deser_data_val_o), 32'(0));
    check("rst_busy", 32'(bus.busy_o),           32'(0));

    // Reset wins over a valid bit in the same cycle.
    cyc_drive(1'b1, 1'b1);
    check("rst_prio_busy", 32'(bus.busy_o), 32'(0));

    // First burst begins in the first cycle with reset low.
    srst_i = 1'b0;
    send_burst(16'hA5C3, 16, 1'b0);
    check("full_busy_clear", 32'(bus.busy_o), 32'(0));
    idle(2);

    // 5-bit partial word 1,0,1,1,0.
    send_burst(16'hB000, 3, 1'b0);
    check("partial_busy_mid", 32'(bus.busy_o), 32'(1));
    bus.ser_data_val_i = 1'b1; bus.ser_data_i = 1'b1;
    @(posedge clk_i); #1;
    bus.ser_data_i = 1'b0;
    @(posedge clk_i); #1;
    expect_word(16'hB000, 5);
    cyc_drive(1'b0, 1'b1);
    idle(2);

    // 2-bit burst: rejected, busy for two cycles, outputs held.
    cyc_drive(1'b1, 1'b1);
    check("short2_busy1", 32'(bus.busy_o), 32'(1));
    cyc_drive(1'b1, 1'b1);
    check("short2_busy2", 32'(bus.busy_o), 32'(1));
    cyc_drive(1'b0, 1'b1);
    check("short2_busy_end", 32'(bus.busy_o), 32'(0));
    idle(2);
    check("short2_hold_data", 32'(bus.deser_data_o),     32'(16'hB000));
    check("short2_hold_mod",  32'(bus.deser_data_mod_o), 32'(5));

    // 1-bit burst: rejected.
    send_burst(16'h8000, 1, 1'b1);
    idle(1);

    // Boundary lengths 3 and 15.
    send_burst(16'hE000, 3, 1'b1);
    idle(1);
    send_burst(16'h5A5B, 15, 1'b1);
    idle(1);

    // Back-to-back full words, pulses 16 cycles apart.
    send_burst(16'h1234, 16, 1'b0);
    send_burst(16'hFFFF, 16, 1'b1);
    idle(2);

    // Reset after 8 bits discards the burst.
    send_burst(16'hFFFF, 8, 1'b0);
    check("mid_busy", 32'(bus.busy_o), 32'(1));
    srst_i = 1'b1;
    cyc_drive(1'b1, 1'b1);
    check("mid_rst_busy", 32'(bus.busy_o),           32'(0));
    check("mid_rst_val",  32'(bus.deser_data_val_o), 32'(0));
    check("mid_rst_data", 32'(bus.deser_data_o),     32'(0));
    srst_i = 1'b0;
    send_burst(16'h0F0F, 16, 1'b1);
    idle(2);

    // Random loopback, mod in {0,3..15}, random idle gaps.
    for (int t = 0; t < 40; t++) begin
      rw = W'($urandom);
      rm = int'($urandom_range(0, 13));
      rm = (rm == 0) ? 0 : rm + 2;
      send_burst(rw, (rm == 0) ? 16 : rm, 1'b1);
      idle(int'($urandom_range(0, 2)));
    end

    idle(4);
    check("queue_drained", 32'(sb_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 The block SHALL have parameter DATA_BUS_WIDTH, default 16, giving the parallel word width in bits.
REQ-002 The block SHALL have parameter DATA_MOD_WIDTH, default 4, giving the width of the valid-bit-count field; DATA_BUS_WIDTH SHALL equal 2**DATA_MOD_WIDTH.
REQ-003 The block SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port srst_i  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port ser_data_i  input  1  serial data bit, MSB of the word first.
REQ-006 The block SHALL have port ser_data_val_i  input  1  qualifies ser_data_i; one bit accepted per cycle it is high.
REQ-007 The block SHALL have port deser_data_o  output  DATA_BUS_WIDTH  assembled word.
REQ-008 The block SHALL have port deser_data_mod_o  output  DATA_MOD_WIDTH  count of valid bits in deser_data_o; 0 means all DATA_BUS_WIDTH bits are valid.
REQ-009 The block SHALL have port deser_data_val_o  output  1  one-cycle pulse qualifying deser_data_o and deser_data_mod_o.
REQ-010 The block SHALL have port busy_o  output  1  high while a burst is partially collected.

Function
REQ-011 A burst SHALL be a maximal run of consecutive cycles with ser_data_val_i high, capped at DATA_BUS_WIDTH bits.
REQ-012 The FSM SHALL have states IDLE_S and RECV_S; IDLE_S->RECV_S when ser_data_val_i=1 in IDLE_S; RECV_S->IDLE_S when ser_data_val_i=0 or a full word completes with ser_data_val_i then low.
REQ-013 A bit count register (DATA_MOD_WIDTH+1 bits wide, range 0..DATA_BUS_WIDTH) SHALL count bits accepted in the current burst and SHALL be 0 in IDLE_S.
REQ-014 The k-th bit of a burst (k=1..N) SHALL be stored at deser_data_o index DATA_BUS_WIDTH-k, left-aligning the data; bits below index DATA_BUS_WIDTH-N SHALL be 0 in the emitted word.
REQ-015 When the DATA_BUS_WIDTH-th bit is accepted at edge E, the block SHALL assert deser_data_val_o in the cycle after E, with deser_data_mod_o=0.
REQ-016 When ser_data_val_i is low in RECV_S with count N (3<=N<DATA_BUS_WIDTH), the block SHALL assert deser_data_val_o in the following cycle with deser_data_mod_o=N.
REQ-017 Bursts shorter than 3 bits SHALL be discarded with no deser_data_val_o pulse, so 1- and 2-bit transactions are rejected.
REQ-018 If ser_data_val_i stays high in the cycle after a full word completes, that bit SHALL be the first bit of a new burst with no lost cycle (back-to-back words).
REQ-019 deser_data_o and deser_data_mod_o SHALL hold their last emitted values until the next pulse; deser_data_val_o SHALL never be high for two consecutive cycles from a single burst.
REQ-020 busy_o SHALL be high in any cycle where the count is nonzero, and low otherwise.
REQ-021 ser_data_i SHALL be ignored in every cycle where ser_data_val_i is low.
REQ-022 Latency SHALL be exactly 1 cycle from the last accepted bit (full word) or from the terminating low-valid cycle (partial word) to deser_data_val_o.

Reset
REQ-023 While srst_i is high: state=IDLE_S, count=0, deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0, busy_o=0.
REQ-024 Reset during RECV_S SHALL discard the partial burst with no output pulse; srst_i SHALL take priority over ser_data_val_i in the same cycle.
REQ-025 The first burst after reset SHALL be accepted starting in the first cycle with srst_i low.

Verification
REQ-026 16 valid bits of 16'hA5C3, MSB first -> one pulse, deser_data_o=16'hA5C3, deser_data_mod_o=0, 1 cycle after the last bit.
REQ-027 5 bits 1,0,1,1,0 then valid low -> one pulse, deser_data_o=16'hB000, deser_data_mod_o=5.
REQ-028 2-bit burst 1,1 then valid low -> no pulse; busy_o high 2 cycles, then 0; outputs unchanged.
REQ-029 32 contiguous valid bits 16'h1234 then 16'hFFFF -> two pulses 16 cycles apart, values 16'h1234 then 16'hFFFF, both with mod 0.
REQ-030 srst_i high after 8 bits of a burst -> no pulse, busy_o=0 next cycle; a following 16-bit burst of 16'h0F0F is received correctly.
REQ-031 A serializer-to-deserializer loopback with random data and mod in {0,3..15} SHALL reproduce data_i masked to its top N bits and mod equal to data_mod_i.
